axis_pkt_source: RTL and testbench
==================================

AXIS_PKT_SOURCE -- requirements
Module: axis_pkt_source

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the data width in bits of the write port and the stream.
REQ-002 SHALL provide parameter DEPTH, default 16, the message buffer entries; power of two, at least 2.
REQ-003 SHALL provide parameter LFSR_SEED, default all-ones, the non-zero LFSR seed loaded at reset and at each start.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 wr_en  in  1  buffer write strobe.
REQ-007 wr_addr  in  clog2(DEPTH)  buffer write address.
REQ-008 wr_data  in  WIDTH  buffer write data.
REQ-009 pkt_len  in  clog2(DEPTH)+1  beats per packet, 1..DEPTH.
REQ-010 mode  in  2  0=buffer one-shot, 1=buffer repeat, 2=LFSR one-shot, 3=reserved (treated as 0).
REQ-011 start  in  1  launch request.
REQ-012 stop  in  1  end repeat mode after the current packet.
REQ-013 m_axis_tready  in  1  sink ready.
REQ-014 m_axis_tvalid  out  1  beat valid.
REQ-015 m_axis_tdata  out  WIDTH  beat data.
REQ-016 m_axis_tlast  out  1  final beat of the packet.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse when a run completes.
REQ-019 pkt_cnt  out  16  packets completed since start; wraps at 2^16.

Function
REQ-020 SHALL use states IDLE, SEND and FLUSH; FLUSH lasts one cycle, asserts done, then returns to IDLE.
REQ-021 In IDLE, start with pkt_len in 1..DEPTH SHALL latch pkt_len and mode, clear the beat index and pkt_cnt, reload the LFSR, and enter SEND.
REQ-022 start with pkt_len of 0 or greater than DEPTH SHALL be ignored.
REQ-023 start while busy SHALL be ignored.
REQ-024 m_axis_tvalid SHALL rise on the cycle after start is accepted, carrying beat 0 (buf[0], or the LFSR seed in mode 2).
REQ-025 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable.
REQ-026 tvalid SHALL never depend combinationally on tready.
REQ-027 On each handshake (tvalid and tready) the next beat SHALL be presented on the following cycle with no bubble, giving full throughput of 1 beat/cycle.
REQ-028 tlast SHALL be 1 only on the beat whose index equals latched pkt_len-1.
REQ-029 Mode 2 SHALL advance an 8-bit-tap Galois LFSR of WIDTH bits once per handshake, with data equal to the LFSR state.
REQ-030 On the tlast handshake pkt_cnt SHALL increment.
REQ-031 On the tlast handshake in one-shot modes, the block SHALL enter FLUSH.
REQ-032 On the tlast handshake in mode 1 with no pending stop, the index SHALL wrap to 0 and SEND SHALL continue without a bubble.
REQ-033 stop seen any cycle during SEND SHALL set a sticky flag; the mode-1 run SHALL end at the next tlast handshake.
REQ-034 stop in IDLE SHALL be ignored.
REQ-035 In IDLE, wr_en SHALL write wr_data to buf[wr_addr].
REQ-036 While busy, wr_en SHALL be ignored and the buffer SHALL stay unchanged.

Reset
REQ-037 rst SHALL force IDLE and clear tvalid, tdata, tlast, busy, done, pkt_cnt, the index and the stop flag, and load the LFSR with LFSR_SEED, including mid-packet.
REQ-038 Buffer contents SHALL NOT be reset.

Structure
REQ-039 A shared package SHALL hold the mode encodings, the state encodings and the LFSR tap constant.
REQ-040 The LFSR SHALL be a sub-module named axis_lfsr (WIDTH, seed, load, advance).

Verification
REQ-041 Write buf[0..5]="HELLO\n", mode 0, pkt_len 6, tready=1 -> 6 consecutive beats 48 45 4C 4C 4F 0A; tlast on 0A; done one cycle later; pkt_cnt=1.
REQ-042 Same as REQ-041 with tready toggling 1010... -> identical byte order; data/last held during stalls; no beat dropped or duplicated.
REQ-043 Mode 1, pkt_len 3, stop pulsed mid second packet -> exactly 6 beats, tlast on beats 3 and 6, pkt_cnt=2, done once.
REQ-044 Mode 2, pkt_len 4, seed 0xFF -> first beat 0xFF; next three match the reference LFSR model; a second run repeats the same sequence.
REQ-045 rst asserted at beat 2 of 6 -> tvalid=0 immediately; busy=0; a following start with pkt_len 6 replays from beat 0.
REQ-046 start with pkt_len 0, and wr_en while busy -> no beats, busy stays 0 for the first; buffer unchanged for the second.

Source files
------------

// File: rtl/axis_pkt_source_pkg.sv
// Shared encodings for the AXI-Stream packet source: run modes, FSM states
// and the Galois LFSR feedback taps.
package axis_pkt_source_pkg;

  typedef enum logic [1:0] {
    MODE_BUF_ONCE   = 2'd0,
    MODE_BUF_REPEAT = 2'd1,
    MODE_LFSR_ONCE  = 2'd2,
    MODE_RESERVED   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Right-shifting Galois taps for x^8 + x^6 + x^5 + x^4 + 1 (maximal length at 8 bits)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // The reserved encoding behaves as buffer one-shot
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == MODE_RESERVED) ? MODE_BUF_ONCE : mode_e'(m);
  endfunction

endpackage

// File: rtl/axis_lfsr.sv
// WIDTH-bit right-shifting Galois LFSR; load restores the seed, advance steps once.
module axis_lfsr
  import axis_pkt_source_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/axis_pkt_source.sv
// AXI-Stream packet generator: streams a preloaded message buffer (one-shot
// or repeating) or an LFSR sequence, one beat per cycle with tlast framing.
module axis_pkt_source
  import axis_pkt_source_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_SEED = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   pkt_len,
  input  logic [1:0]               mode,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic             stop_q, stop_d;
  logic [LW-1:0]    len_q, len_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             lfsr_load, lfsr_adv;
  logic [WIDTH-1:0] lfsr_state;
  logic             len_ok, last_beat, hs;

  axis_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign len_ok    = (pkt_len != '0) && (pkt_len <= LW'(DEPTH));
  assign last_beat = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign hs        = (state_q == ST_SEND) && m_axis_tready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    stop_d    = stop_q;
    len_d     = len_q;
    mode_d    = mode_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok) begin
          len_d     = pkt_len;
          mode_d    = norm_mode(mode);
          idx_d     = '0;
          pkt_cnt_d = '0;
          stop_d    = 1'b0;
          lfsr_load = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (stop) stop_d = 1'b1;
        if (hs) begin
          lfsr_adv = 1'b1;
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            idx_d     = '0;
            // A stop arriving on the final beat itself still ends the run here
            if (!(mode_q == MODE_BUF_REPEAT && !stop_q && !stop)) begin
              state_d = ST_FLUSH;
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      stop_q    <= stop_d;
    end
  end

  // Run configuration is only meaningful once a start has been accepted
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    mode_q <= mode_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == ST_IDLE)) mem_q[wr_addr] <= wr_data;
  end

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = !m_axis_tvalid ? '0 :
                         (mode_q == MODE_LFSR_ONCE) ? lfsr_state : mem_q[idx_q];
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FLUSH);
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_source.sv
// Directed bench for axis_pkt_source: expected beats come from a message/LFSR
// model queue, checked every cycle, plus literal checks on captured bytes.
module tb_axis_pkt_source;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             rst, wr_en, start, stop, tready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [LW-1:0]    pkt_len;
  logic [1:0]       mode;
  logic             tvalid, tlast, busy, done;
  logic [WIDTH-1:0] tdata;
  logic [15:0]      pkt_cnt;

  axis_pkt_source #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LFSR_SEED(8'hFF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_len(pkt_len), .mode(mode), .start(start), .stop(stop),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];
  logic [7:0] mem_m [DEPTH];
  logic [7:0] cap [64];
  int beats_seen = 0, lasts_seen = 0, done_cnt = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0, launch_cyc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, prev_d);
        chk("hold_last", tlast, prev_l);
      end
      if (tvalid) begin
        chk("valid_busy", busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %02h expected no beat", tdata);
        end else begin
          chk("beat_data", tdata, exp_q[0][7:0]);
          chk("beat_last", tlast, exp_q[0][8]);
          if (tready) void'(exp_q.pop_front());
        end
        if (tready) begin
          if (beats_seen < 64) cap[beats_seen] = tdata;
          if (beats_seen == 0) first_cyc = cyc;
          beats_seen++;
          if (tlast) begin
            last_cyc = cyc;
            lasts_seen++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_v = tvalid && !rst;
    prev_r = tready;
    prev_d = tdata;
    prev_l = tlast;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [7:0] d, input bit upd_model);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (upd_model) mem_m[a] = d;
  endtask

  task automatic launch(input int len, input int md);
    @(posedge clk); #1;
    pkt_len = LW'(len); mode = 2'(md); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    launch_cyc = cyc;
  endtask

  task automatic push_buf(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), mem_m[i]});
  endtask

  task automatic push_lfsr(input int len);
    logic [7:0] s;
    s = 8'hFF;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), s});
      s = lfsr_next(s);
    end
  endtask

  task automatic clear_stats();
    beats_seen = 0; lasts_seen = 0; done_cnt = 0;
  endtask

  task automatic wait_done(input int maxc, input bit tog);
    int d0;
    bit hit;
    d0 = done_cnt;
    hit = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk); #1;
      if (tog) tready = ~tready;
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", maxc);
    end
  endtask

  task automatic wait_beats(input int n, input int maxc);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #1;
      if (beats_seen >= n) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", beats_seen, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    wr_addr = '0; wr_data = '0; pkt_len = '0; mode = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    write_mem(0, 8'h48, 1); write_mem(1, 8'h45, 1); write_mem(2, 8'h4C, 1);
    write_mem(3, 8'h4C, 1); write_mem(4, 8'h4F, 1); write_mem(5, 8'h0A, 1);

    // HELLO one-shot at full throughput
    clear_stats(); tready = 1'b1; push_buf(6);
    launch(6, 0);
    wait_done(40, 0);
    chk("hello_first_latency", first_cyc, launch_cyc);
    chk("hello_no_bubble", last_cyc - first_cyc, 5);
    chk("hello_done_after_last", done_cyc, last_cyc + 1);
    tick(3);
    chk("hello_beats", beats_seen, 6);
    chk("hello_pkt_cnt", pkt_cnt, 1);
    chk("hello_done_once", done_cnt, 1);
    chk("hello_busy_after", busy, 0);
    chk("hello_q_empty", exp_q.size(), 0);
    chk("hello_cap0", cap[0], 8'h48);
    chk("hello_cap5", cap[5], 8'h0A);

    // HELLO with stalls and a start while busy
    clear_stats(); tready = 1'b1; push_buf(6);
    launch(6, 0);
    @(posedge clk); #1;
    tready = 1'b0; pkt_len = 5'd3; mode = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tready = 1'b1;
    wait_done(40, 1);
    tick(3);
    chk("stall_beats", beats_seen, 6);
    chk("stall_pkt_cnt", pkt_cnt, 1);
    chk("stall_done_once", done_cnt, 1);
    chk("stall_cap1", cap[1], 8'h45);
    chk("stall_cap4", cap[4], 8'h4F);
    chk("stall_q_empty", exp_q.size(), 0);

    // repeat mode, stop mid second packet
    clear_stats(); tready = 1'b1; push_buf(3); push_buf(3);
    launch(3, 1);
    wait_beats(4, 30);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(30, 0);
    tick(4);
    chk("rep_beats", beats_seen, 6);
    chk("rep_lasts", lasts_seen, 2);
    chk("rep_pkt_cnt", pkt_cnt, 2);
    chk("rep_done_once", done_cnt, 1);
    chk("rep_cap3", cap[3], 8'h48);
    chk("rep_q_empty", exp_q.size(), 0);

    // LFSR one-shot, twice
    for (int run = 0; run < 2; run++) begin
      clear_stats(); tready = 1'b1; push_lfsr(4);
      launch(4, 2);
      wait_done(30, 0);
      tick(2);
      chk("lfsr_beats", beats_seen, 4);
      chk("lfsr_cap0", cap[0], 8'hFF);
      chk("lfsr_cap1", cap[1], 8'hC7);
      chk("lfsr_cap2", cap[2], 8'hDB);
      chk("lfsr_cap3", cap[3], 8'hD5);
      chk("lfsr_pkt_cnt", pkt_cnt, 1);
    end

    // reset mid-packet, then replay
    clear_stats(); tready = 1'b1; push_buf(6);
    launch(6, 0);
    wait_beats(2, 20);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tdata", tdata, 0);
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats(); push_buf(6);
    launch(6, 0);
    wait_done(40, 0);
    tick(2);
    chk("replay_beats", beats_seen, 6);
    chk("replay_cap0", cap[0], 8'h48);
    chk("replay_pkt_cnt", pkt_cnt, 1);

    // illegal lengths and stop in IDLE are ignored
    clear_stats();
    launch(0, 0);
    tick(3);
    chk("len0_busy", busy, 0);
    launch(17, 0);
    tick(3);
    chk("len17_busy", busy, 0);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    tick(3);
    chk("illegal_no_beats", beats_seen, 0);
    chk("illegal_no_done", done_cnt, 0);

    // writes while busy leave the buffer unchanged
    clear_stats(); tready = 1'b0; push_buf(6);
    launch(6, 0);
    write_mem(0, 8'h5A, 0);
    write_mem(1, 8'h59, 0);
    tready = 1'b1;
    wait_done(40, 0);
    tick(2);
    clear_stats(); push_buf(6);
    launch(6, 0);
    wait_done(40, 0);
    tick(2);
    chk("wrbusy_cap0", cap[0], 8'h48);
    chk("wrbusy_cap1", cap[1], 8'h45);
    chk("wrbusy_beats", beats_seen, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
